// File: rtl/router_buffered_if.sv
// Handshake bundle for router_buffered: three input ports (east, west, local
// injection) and three output ports (east, west, scheduler).
// master = the environment around the router, slave = the router itself.
interface router_buffered_if #(
   parameter int PKT_W = 34
);
   logic [PKT_W-1:0] in_east_data;
   logic [PKT_W-1:0] in_west_data;
   logic [PKT_W-1:0] in_local_data;
   logic             in_east_valid;
   logic             in_west_valid;
   logic             in_local_valid;
   logic             in_east_ready;
   logic             in_west_ready;
   logic             in_local_ready;

   logic [PKT_W-1:0] out_east_data;
   logic [PKT_W-1:0] out_west_data;
   logic [PKT_W-1:0] out_sched_data;
   logic             out_east_valid;
   logic             out_west_valid;
   logic             out_sched_valid;
   logic             out_east_ready;
   logic             out_west_ready;
   logic             out_sched_ready;

   modport master (
      output in_east_data, in_west_data, in_local_data,
      output in_east_valid, in_west_valid, in_local_valid,
      input  in_east_ready, in_west_ready, in_local_ready,
      input  out_east_data, out_west_data, out_sched_data,
      input  out_east_valid, out_west_valid, out_sched_valid,
      output out_east_ready, out_west_ready, out_sched_ready
   );

   modport slave (
      input  in_east_data, in_west_data, in_local_data,
      input  in_east_valid, in_west_valid, in_local_valid,
      output in_east_ready, in_west_ready, in_local_ready,
      output out_east_data, out_west_data, out_sched_data,
      output out_east_valid, out_west_valid, out_sched_valid,
      input  out_east_ready, out_west_ready, out_sched_ready
   );
endinterface

// File: rtl/router_buffered.sv
// Buffered 1-D chain router: one FIFO per input (east, west, local), dest
// compare against core_id, round-robin arbitration per output (east, west,
// sched) into one-entry output registers. Never drops, only backpressures.
// Optional: define ROUTER_STATS_EN for saturating handshake/stall counters.
// Internal index order: inputs 0=east 1=west 2=local, outputs 0=east 1=west 2=sched.
module router_buffered #(
   parameter int PKT_W      = 34,
   parameter int CORE_ID_W  = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CORE_ID_W-1:0] core_id,
   router_buffered_if.slave     bus
`ifdef ROUTER_STATS_EN
   ,
   output logic [15:0]          stat_east_cnt,
   output logic [15:0]          stat_west_cnt,
   output logic [15:0]          stat_sched_cnt,
   output logic [15:0]          stat_stall_cnt
`endif
);

   localparam int         PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

   logic [PKT_W-1:0] r_mem [3][FIFO_DEPTH];
   logic [PW-1:0]    r_wptr [3];
   logic [PW-1:0]    r_rptr [3];
   logic [PW:0]      r_cnt [3];
   logic             r_rdy_en;
   logic [1:0]       r_ptr [3];
   logic [2:0]       r_out_valid;
   logic [PKT_W-1:0] r_out_data [3];

   logic [2:0]       w_in_valid, w_in_ready, w_push, w_pop, w_empty;
   logic [2:0]       w_out_ready, w_load;
   logic [PKT_W-1:0] w_in_data [3];
   logic [PKT_W-1:0] w_head [3];
   logic [1:0]       w_route [3];
   logic [2:0]       w_gnt [3];
   logic [PKT_W-1:0] w_sel_data [3];

   // Position k in round-robin order starting at input p.
   function automatic int rr_pos(input logic [1:0] p, input int k);
      int s;
      s = int'(p) + k;
      return (s >= 3) ? s - 3 : s;
   endfunction

   assign w_in_valid   = {bus.in_local_valid, bus.in_west_valid, bus.in_east_valid};
   assign w_in_data[0] = bus.in_east_data;
   assign w_in_data[1] = bus.in_west_data;
   assign w_in_data[2] = bus.in_local_data;
   assign w_out_ready  = {bus.out_sched_ready, bus.out_west_ready, bus.out_east_ready};

   assign bus.in_east_ready   = w_in_ready[0];
   assign bus.in_west_ready   = w_in_ready[1];
   assign bus.in_local_ready  = w_in_ready[2];
   assign bus.out_east_data   = r_out_data[0];
   assign bus.out_west_data   = r_out_data[1];
   assign bus.out_sched_data  = r_out_data[2];
   assign bus.out_east_valid  = r_out_valid[0];
   assign bus.out_west_valid  = r_out_valid[1];
   assign bus.out_sched_valid = r_out_valid[2];

   // FIFO status, push qualification and route decode of each head.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         w_empty[i]    = (r_cnt[i] == '0);
         w_in_ready[i] = r_rdy_en && (r_cnt[i] != FULL_CNT);
         w_push[i]     = w_in_valid[i] && w_in_ready[i];
         w_head[i]     = r_mem[i][r_rptr[i]];
         if (w_head[i][PKT_W-1 -: CORE_ID_W] == core_id)
            w_route[i] = 2'd2;
         else if (w_head[i][PKT_W-1 -: CORE_ID_W] > core_id)
            w_route[i] = 2'd0;
         else
            w_route[i] = 2'd1;
      end
   end

   // Per-output round-robin grant among heads routed to that output.
   always_comb begin
      for (int y = 0; y < 3; y++) begin
         w_gnt[y]      = '0;
         w_sel_data[y] = '0;
         w_load[y]     = !r_out_valid[y] || w_out_ready[y];
         for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
               if (w_load[y] && (w_gnt[y] == 3'b000) && (i == rr_pos(r_ptr[y], k)) &&
                   !w_empty[i] && (w_route[i] == 2'(y))) begin
                  w_gnt[y][i]   = 1'b1;
                  w_sel_data[y] = w_head[i];
               end
            end
         end
      end
   end

   // A head routes to exactly one output, so OR-ing grants pops at most once.
   always_comb begin
      for (int i = 0; i < 3; i++)
         w_pop[i] = w_gnt[0][i] | w_gnt[1][i] | w_gnt[2][i];
   end

   // Input ready is held low during reset and for the release edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_rdy_en <= 1'b0;
      else      r_rdy_en <= 1'b1;
   end

   // FIFO pointers and occupancy count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            r_wptr[i] <= '0;
            r_rptr[i] <= '0;
            r_cnt[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (w_push[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
            if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PW'(1);
            case ({w_push[i], w_pop[i]})
               2'b10:   r_cnt[i] <= r_cnt[i] + (PW+1)'(1);
               2'b01:   r_cnt[i] <= r_cnt[i] - (PW+1)'(1);
               default: r_cnt[i] <= r_cnt[i];
            endcase
         end
      end
   end

   // FIFO storage; contents need no reset since the count gates visibility.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++)
         if (w_push[i]) r_mem[i][r_wptr[i]] <= w_in_data[i];
   end

   // Output registers and round-robin pointers; stalled outputs hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid <= '0;
         for (int y = 0; y < 3; y++) begin
            r_out_data[y] <= '0;
            r_ptr[y]      <= 2'd0;
         end
      end else begin
         for (int y = 0; y < 3; y++) begin
            if (w_load[y]) r_out_valid[y] <= |w_gnt[y];
            if (|w_gnt[y]) begin
               r_out_data[y] <= w_sel_data[y];
               r_ptr[y]      <= w_gnt[y][0] ? 2'd1 : (w_gnt[y][1] ? 2'd2 : 2'd0);
            end
         end
      end
   end

`ifdef ROUTER_STATS_EN
   logic [15:0] r_stat [4];

   // Saturating counters: output handshakes (0..2) and input stall cycles (3).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < 4; s++) r_stat[s] <= '0;
      end else begin
         for (int y = 0; y < 3; y++)
            if (r_out_valid[y] && w_out_ready[y] && (r_stat[y] != 16'hFFFF))
               r_stat[y] <= r_stat[y] + 16'd1;
         if ((|(w_in_valid & ~w_in_ready)) && (r_stat[3] != 16'hFFFF))
            r_stat[3] <= r_stat[3] + 16'd1;
      end
   end

   assign stat_east_cnt  = r_stat[0];
   assign stat_west_cnt  = r_stat[1];
   assign stat_sched_cnt = r_stat[2];
   assign stat_stall_cnt = r_stat[3];
`endif

endmodule
